// File: rtl/lsu.sv
// RV32I load/store unit: one word-aligned memory transaction per instruction, core stalled until done.
// Latency 3 cycles legal (IDLE/REQ/DONE), 2 cycles illegal; REQ waits on mem_ack up to TIMEOUT cycles.
module lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic              req_n, we_n, err_n;
  logic [3:0]        be_n;
  logic [31:0]       addr_n, wd_n, rdata_n;
  logic [2:0]        f3_q, f3_n;
  logic [1:0]        off_q, off_n;

  logic [1:0]        size;
  logic              misaligned, bad_f3, illegal;
  logic [3:0]        be_dec;
  logic [31:0]       wd_dec;
  logic [31:0]       shifted, load_fmt;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign size       = funct3[1:0];
  assign misaligned = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
  assign bad_f3     = is_store ? (funct3 >= 3'd3)
                               : ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
  assign illegal    = misaligned || bad_f3;

  always_comb begin
    be_dec = 4'b1111;
    wd_dec = wdata;
    case (size)
      2'd0: begin
        be_dec = 4'b0001 << addr[1:0];
        wd_dec = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_dec = addr[1] ? 4'b1100 : 4'b0011;
        wd_dec = {2{wdata[15:0]}};
      end
      default: begin
        be_dec = 4'b1111;
        wd_dec = wdata;
      end
    endcase
  end

  // Lane selection uses the byte offset captured at issue, since mem_addr is word aligned.
  assign shifted = mem_rdata >> {off_q, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'd0:    load_fmt = {{24{lane_b[7]}}, lane_b};
      3'd1:    load_fmt = {{16{lane_h[15]}}, lane_h};
      3'd4:    load_fmt = {24'b0, lane_b};
      3'd5:    load_fmt = {16'b0, lane_h};
      default: load_fmt = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt + CNT_W'(1);
  assign stall   = req_valid && (state != DONE);
  assign done    = (state == DONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = mem_req;
    we_n    = mem_we;
    be_n    = mem_be;
    addr_n  = mem_addr;
    wd_n    = mem_wdata;
    rdata_n = rdata;
    err_n   = err;
    f3_n    = f3_q;
    off_n   = off_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            state_n = DONE;
            err_n   = 1'b1;
            rdata_n = 32'b0;
          end else begin
            state_n = REQ;
            req_n   = 1'b1;
            we_n    = is_store;
            be_n    = be_dec;
            addr_n  = {addr[31:2], 2'b00};
            wd_n    = wd_dec;
            f3_n    = funct3;
            off_n   = addr[1:0];
            cnt_n   = '0;
          end
        end
      end
      REQ: begin
        cnt_n = cnt_inc;
        if (mem_ack) begin
          state_n = DONE;
          req_n   = 1'b0;
          err_n   = 1'b0;
          rdata_n = mem_we ? 32'b0 : load_fmt;
        end else if ((TIMEOUT != 0) && (cnt_inc == TMO)) begin
          state_n = DONE;
          req_n   = 1'b0;
          err_n   = 1'b1;
          rdata_n = 32'b0;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
        err_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'b0;
      mem_wdata <= 32'b0;
      rdata     <= 32'b0;
      err       <= 1'b0;
      f3_q      <= 3'b0;
      off_q     <= 2'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_be    <= be_n;
      mem_addr  <= addr_n;
      mem_wdata <= wd_n;
      rdata     <= rdata_n;
      err       <= err_n;
      f3_q      <= f3_n;
      off_q     <= off_n;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a short timeout so the abort path is reachable quickly.
module tb_lsu;

  logic        clk, rst;
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    #1;
    chk("stall_issue", {31'b0, stall}, 32'd1);
  endtask

  task automatic check_req(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                           input logic ewe);
    chk({tag, "_req"},   {31'b0, mem_req}, 32'd1);
    chk({tag, "_addr"},  mem_addr, ea);
    chk({tag, "_be"},    {28'b0, mem_be}, {28'b0, ebe});
    chk({tag, "_we"},    {31'b0, mem_we}, {31'b0, ewe});
    chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic [31:0] erd, input logic eerr);
    chk({tag, "_done"},    {31'b0, done}, 32'd1);
    chk({tag, "_err"},     {31'b0, err}, {31'b0, eerr});
    chk({tag, "_rdata"},   rdata, erd);
    chk({tag, "_stall"},   {31'b0, stall}, 32'd0);
    chk({tag, "_reqdone"}, {31'b0, mem_req}, 32'd0);
    req_valid = 1'b0;
    tick();
    chk({tag, "_idle_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_err"},  {31'b0, err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'b0; wdata = 32'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    chk("rst_be",    {28'b0, mem_be}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    // LW, ack in first REQ cycle
    start(1'b0, 3'd2, 32'h100, 32'h0);
    tick();
    check_req("lw", 32'h100, 4'b1111, 1'b0);
    ack(32'hDEADBEEF);
    finish_done("lw", 32'hDEADBEEF, 1'b0);

    // LB at byte 3, three wait cycles, ack lands on the timeout boundary cycle
    start(1'b0, 3'd0, 32'h203, 32'h0);
    tick();
    check_req("lb", 32'h200, 4'b1000, 1'b0);
    tick();
    tick();
    tick();
    chk("lb_wait_req", {31'b0, mem_req}, 32'd1);
    chk("lb_wait_done", {31'b0, done}, 32'd0);
    ack(32'h80FF1234);
    finish_done("lb", 32'hFFFFFF80, 1'b0);

    start(1'b0, 3'd4, 32'h203, 32'h0);
    tick();
    check_req("lbu", 32'h200, 4'b1000, 1'b0);
    ack(32'h80FF1234);
    finish_done("lbu", 32'h00000080, 1'b0);

    // Misaligned LW: no request, done next cycle
    start(1'b0, 3'd2, 32'h102, 32'h0);
    tick();
    finish_done("lw_mis", 32'h0, 1'b1);

    start(1'b0, 3'd1, 32'h202, 32'h0);
    tick();
    check_req("lh", 32'h200, 4'b1100, 1'b0);
    ack(32'h80FF1234);
    finish_done("lh", 32'hFFFF80FF, 1'b0);

    // Timeout after 4 REQ cycles, then a late ack is ignored
    start(1'b0, 3'd2, 32'h300, 32'h0);
    tick();
    check_req("tmo", 32'h300, 4'b1111, 1'b0);
    tick();
    tick();
    tick();
    chk("tmo_c4_req", {31'b0, mem_req}, 32'd1);
    tick();
    finish_done("tmo", 32'h0, 1'b1);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_req",  {31'b0, mem_req}, 32'd0);
    chk("late_ack_done", {31'b0, done}, 32'd0);

    start(1'b0, 3'd5, 32'h200, 32'h0);
    tick();
    check_req("lhu", 32'h200, 4'b0011, 1'b0);
    ack(32'h80FF1234);
    finish_done("lhu", 32'h00001234, 1'b0);

    start(1'b1, 3'd0, 32'h41, 32'h000000AB);
    tick();
    check_req("sb", 32'h40, 4'b0010, 1'b1);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    ack(32'hFFFFFFFF);
    finish_done("sb", 32'h0, 1'b0);

    start(1'b1, 3'd1, 32'h42, 32'h00001234);
    tick();
    check_req("sh", 32'h40, 4'b1100, 1'b1);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    ack(32'h0);
    finish_done("sh", 32'h0, 1'b0);

    start(1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
    tick();
    check_req("sw", 32'h44, 4'b1111, 1'b1);
    chk("sw_wdata", mem_wdata, 32'hCAFEF00D);
    ack(32'h0);
    finish_done("sw", 32'h0, 1'b0);

    start(1'b1, 3'd1, 32'h45, 32'h00001234);
    tick();
    finish_done("sh_mis", 32'h0, 1'b1);

    start(1'b0, 3'd3, 32'h100, 32'h0);
    tick();
    finish_done("ld_f3", 32'h0, 1'b1);

    // Reset while in REQ abandons the access
    start(1'b0, 3'd2, 32'h400, 32'h0);
    tick();
    check_req("rstreq", 32'h400, 4'b1111, 1'b0);
    rst = 1'b1;
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstreq_req",  {31'b0, mem_req}, 32'd0);
    chk("rstreq_done", {31'b0, done}, 32'd0);
    chk("rstreq_err",  {31'b0, err}, 32'd0);

    start(1'b0, 3'd2, 32'h404, 32'h0);
    tick();
    check_req("post_rst", 32'h404, 4'b1111, 1'b0);
    ack(32'h13579BDF);
    finish_done("post_rst", 32'h13579BDF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
